// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: memory-mapped controller for a WIDTH-bit bank of GPIO pins.
// It holds the enable/direction/output registers that drive the pin cells.
// It synchronises received pin values into IN.
// Bus accesses are sequenced by a three-state IDLE/ACK/WAIT FSM.
// Optional rising-edge interrupt logic is built only when GPIO_PORT_CTRL_IRQ_EN is defined.
// Without that macro, addresses 6/7 read 0 and o_irq is tied low.
//
// Bus handshake (four-phase req/ack):
//   The master raises i_req and holds i_we/i_addr/i_wdata stable until it sees o_ack.
//   In IDLE, the edge that samples i_req=1 commits the access.
//   o_ack (with o_rdata for reads) is then high for exactly one cycle.
//   The FSM then waits in WAIT until i_req is low again, so a held request is served once.
//   o_rdata is 0 whenever o_ack is low.
module gpio_port_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata,
    output logic              o_ack,
    output logic [WIDTH-1:0]  o_pin_enable,
    output logic [WIDTH-1:0]  o_pin_dir,
    output logic [WIDTH-1:0]  o_pin_data,
    input  logic [WIDTH-1:0]  i_pin_data,
    output logic              o_irq,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SET  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CLR  = ADDR_W'(5);
`ifdef GPIO_PORT_CTRL_IRQ_EN
    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(7);
`endif

    state_t             state_q;
    logic [WIDTH-1:0]   ctrl_q;
    logic [WIDTH-1:0]   dir_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   sync1_q;
    logic [WIDTH-1:0]   in_q;
    logic [WIDTH-1:0]   rd_val;
    logic               access;
    logic               wr;

`ifdef GPIO_PORT_CTRL_IRQ_EN
    logic [WIDTH-1:0]   in_prev_q;
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   stat_q;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   w1c;
    logic               irq_q;
`endif

    // An access is committed only on the IDLE edge that samples a request
    assign access = (state_q == ST_IDLE) && i_req;
    assign wr     = access && i_we;

    assign o_pin_enable = ctrl_q;
    assign o_pin_dir    = dir_q;
    assign o_pin_data   = out_q;
    assign o_dbg_state  = state_q;

    // Read mux: register contents before any same-edge update; WO/unbuilt slots read 0
    always_comb begin
        rd_val = '0;
        case (i_addr)
            A_CTRL:  rd_val = ctrl_q;
            A_DIR:   rd_val = dir_q;
            A_OUT:   rd_val = out_q;
            A_IN:    rd_val = in_q;
`ifdef GPIO_PORT_CTRL_IRQ_EN
            A_MASK:  rd_val = mask_q;
            A_STAT:  rd_val = stat_q;
`endif
            default: rd_val = '0;
        endcase
    end

    // Bus FSM with registered ack and read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            o_ack   <= 1'b0;
            o_rdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        o_ack   <= 1'b1;
                        o_rdata <= i_we ? '0 : rd_val;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    o_ack   <= 1'b0;
                    o_rdata <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!i_req) state_q <= ST_IDLE;
                end
                default: begin
                    o_ack   <= 1'b0;
                    o_rdata <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pin configuration registers, including SET/CLR read-modify-write of OUT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_q <= '0;
            dir_q  <= '0;
            out_q  <= '0;
        end else if (wr) begin
            case (i_addr)
                A_CTRL:  ctrl_q <= i_wdata;
                A_DIR:   dir_q  <= i_wdata;
                A_OUT:   out_q  <= i_wdata;
                A_SET:   out_q  <= out_q | i_wdata;
                A_CLR:   out_q  <= out_q & ~i_wdata;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser; disabled pins are forced to 0 before the first flop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            in_q    <= '0;
        end else begin
            sync1_q <= i_pin_data & ctrl_q;
            in_q    <= sync1_q;
        end
    end

`ifdef GPIO_PORT_CTRL_IRQ_EN
    assign rise = in_q & ~in_prev_q;
    assign w1c  = (wr && (i_addr == A_STAT)) ? i_wdata : '0;

    // Edge detect, sticky status (a new edge beats a same-cycle clear), registered irq
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_prev_q <= '0;
            mask_q    <= '0;
            stat_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            in_prev_q <= in_q;
            if (wr && (i_addr == A_MASK)) mask_q <= i_wdata;
            stat_q <= (stat_q & ~w1c) | (rise & mask_q);
            irq_q  <= |(stat_q & mask_q);
        end
    end

    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Testbench for gpio_port_ctrl: directed bus/pin vectors, a behavioural model of the
// register map checked every cycle, and hand-computed literal expectations.
module tb_gpio_port_ctrl;

    localparam int W  = 8;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [W-1:0]  wdata = '0;
    logic [W-1:0]  pins  = '0;
    logic [W-1:0]  o_rdata, o_pin_enable, o_pin_dir, o_pin_data;
    logic          o_ack, o_irq;
    logic [1:0]    o_dbg_state;

    always #5 clk = ~clk;

    gpio_port_ctrl #(.WIDTH(W), .ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (o_rdata),
        .o_ack        (o_ack),
        .o_pin_enable (o_pin_enable),
        .o_pin_dir    (o_pin_dir),
        .o_pin_data   (o_pin_data),
        .i_pin_data   (pins),
        .o_irq        (o_irq),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Register view of the block as seen from the bus and the pins.
    logic [W-1:0] m_ctrl = '0, m_dir = '0, m_out = '0, m_in = '0, m_in_prev = '0;
    logic         m_irq = 1'b0;
    bit           m_served = 1'b0;
    logic [W-1:0] hist[$] = '{8'h00};
`ifdef GPIO_PORT_CTRL_IRQ_EN
    logic [W-1:0] m_mask = '0, m_stat = '0;
`endif

    function automatic logic [W-1:0] read_model(input logic [AW-1:0] a);
        case (a)
            3'd0: return m_ctrl;
            3'd1: return m_dir;
            3'd2: return m_out;
            3'd3: return m_in;
`ifdef GPIO_PORT_CTRL_IRQ_EN
            3'd6: return m_mask;
            3'd7: return m_stat;
`endif
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [W-1:0] gated, rise, w1c, old_mask;
        logic         irq_next;
        if (!rst_n) begin
            m_ctrl = '0; m_dir = '0; m_out = '0; m_in = '0; m_in_prev = '0;
            m_irq = 1'b0; m_served = 1'b0;
            hist = '{8'h00};
            exp_q.delete();
`ifdef GPIO_PORT_CTRL_IRQ_EN
            m_mask = '0; m_stat = '0;
`endif
        end else begin
            gated    = pins & m_ctrl;
            rise     = m_in & ~m_in_prev;
            w1c      = '0;
            irq_next = 1'b0;
`ifdef GPIO_PORT_CTRL_IRQ_EN
            old_mask = m_mask;
            irq_next = |(m_stat & m_mask);
`else
            old_mask = '0;
`endif
            // one access per request, however long i_req is held
            if (req && !m_served) begin
                m_served = 1'b1;
                if (!we) exp_q.push_back(read_model(addr));
                else begin
                    case (addr)
                        3'd0: m_ctrl = wdata;
                        3'd1: m_dir  = wdata;
                        3'd2: m_out  = wdata;
                        3'd4: m_out  = m_out | wdata;
                        3'd5: m_out  = m_out & ~wdata;
`ifdef GPIO_PORT_CTRL_IRQ_EN
                        3'd6: m_mask = wdata;
                        3'd7: w1c    = wdata;
`endif
                        default: ;
                    endcase
                end
            end else if (!req) begin
                m_served = 1'b0;
            end
`ifdef GPIO_PORT_CTRL_IRQ_EN
            m_stat = (m_stat & ~w1c) | (rise & old_mask);
`endif
            // IN shows the gated pins sampled one edge earlier: a change lands 2 edges later
            hist.push_back(gated);
            m_in_prev = m_in;
            m_in      = hist.pop_front();
            m_irq     = irq_next;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("pin_enable", o_pin_enable, m_ctrl);
        chk("pin_dir", o_pin_dir, m_dir);
        chk("pin_data", o_pin_data, m_out);
        chk("irq", W'(o_irq), W'(m_irq));
        if (!o_ack) chk("rdata_idle", o_rdata, '0);
        if (o_ack) ack_cnt++;
    end

    // ---------------- driver ----------------
    task automatic bus(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                       output logic [W-1:0] rd);
        int n;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        rd = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ack && n < 8);
        total++;
        if (!o_ack || n != 1) begin
            bad++;
            $display("FAIL ack_latency addr=%0d: ack=%0b after %0d cycles, want 1 after 1", a, o_ack, n);
        end
        if (o_ack) begin
            rd = o_rdata;
            if (!w) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdata_queue addr=%0d: got 0x%0h with no expected entry", a, o_rdata);
                end else begin
                    chk($sformatf("rdata_a%0d", a), o_rdata, exp_q.pop_front());
                end
            end
        end
        req = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", W'(o_ack), '0);
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] rd;
    logic [W-1:0] exp_stat, exp_irq;
    int           acks0;

    initial begin
`ifdef GPIO_PORT_CTRL_IRQ_EN
        exp_stat = 8'h04; exp_irq = 8'h01;
`else
        exp_stat = 8'h00; exp_irq = 8'h00;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset values read back, one ack per access
        acks0 = ack_cnt;
        for (int a = 0; a < 8; a++) begin
            bus(1'b0, 3'(a), '0, rd);
            chk($sformatf("reset_rd%0d", a), rd, 8'h00);
        end
        chk("reset_ack_count", 8'(ack_cnt - acks0), 8'd8);

        // configuration writes
        bus(1'b1, 3'd0, 8'hFF, rd);
        bus(1'b1, 3'd1, 8'h0F, rd);
        bus(1'b1, 3'd2, 8'hA5, rd);
        chk("cfg_enable", o_pin_enable, 8'hFF);
        chk("cfg_dir", o_pin_dir, 8'h0F);
        chk("cfg_out", o_pin_data, 8'hA5);

        // SET / CLR
        bus(1'b1, 3'd4, 8'h0A, rd);
        chk("set_out", o_pin_data, 8'hAF);
        bus(1'b1, 3'd5, 8'h21, rd);
        chk("clr_out", o_pin_data, 8'h8E);
        bus(1'b0, 3'd4, '0, rd);
        chk("set_reads0", rd, 8'h00);
        bus(1'b0, 3'd5, '0, rd);
        chk("clr_reads0", rd, 8'h00);
        bus(1'b0, 3'd2, '0, rd);
        chk("out_readback", rd, 8'h8E);

        // input synchronisation and gating
        bus(1'b1, 3'd0, 8'h0F, rd);
        #1 pins = 8'hF3;
        bus(1'b0, 3'd3, '0, rd);
        chk("in_not_early", rd, 8'h00);
        bus(1'b0, 3'd3, '0, rd);
        chk("in_gated", rd, 8'h03);
        #1 pins = 8'bzzzz_0011;
        repeat (3) @(negedge clk);
        bus(1'b0, 3'd3, '0, rd);
        chk("in_z_gated", rd, 8'h03);
        #1 pins = 8'h00;
        repeat (3) @(negedge clk);

        // held request: one ack, one SET
        acks0 = ack_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd4; wdata = 8'h01;
        repeat (10) @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_ack_count", 8'(ack_cnt - acks0), 8'd1);
        chk("hold_out", o_pin_data, 8'h8F);
        bus(1'b0, 3'd2, '0, rd);
        chk("hold_next_access", rd, 8'h8F);

        // interrupt: rising edge on pin 2
        bus(1'b1, 3'd6, 8'h04, rd);
        #1 pins = 8'h04;
        repeat (5) @(negedge clk);
        bus(1'b0, 3'd7, '0, rd);
        chk("irq_stat_set", rd, exp_stat);
        chk("irq_level", W'(o_irq), exp_irq);
        #1 pins = 8'h00;
        repeat (4) @(negedge clk);
        // a fresh edge lands on the same edge as the W1C commit
        @(negedge clk); pins = 8'h04;
        @(negedge clk);
        bus(1'b1, 3'd7, 8'h04, rd);
        bus(1'b0, 3'd7, '0, rd);
        chk("irq_edge_wins", rd, exp_stat);
        bus(1'b1, 3'd7, 8'h04, rd);
        bus(1'b0, 3'd7, '0, rd);
        chk("irq_w1c", rd, 8'h00);
        chk("irq_after_w1c", W'(o_irq), 8'h00);
        // mask clear drops irq but keeps status
        #1 pins = 8'h00;
        repeat (4) @(negedge clk);
        pins = 8'h04;
        repeat (5) @(negedge clk);
        chk("irq_again", W'(o_irq), exp_irq);
        bus(1'b1, 3'd6, 8'h00, rd);
        @(negedge clk);
        chk("irq_masked", W'(o_irq), 8'h00);
        bus(1'b0, 3'd7, '0, rd);
        chk("stat_kept", rd, exp_stat);

        // asynchronous reset in the middle of an access
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd0; wdata = 8'hAA;
        @(posedge clk);
        #2 chk("ack_before_rst", W'(o_ack), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_ack", W'(o_ack), 8'h00);
        chk("rst_enable", o_pin_enable, 8'h00);
        chk("rst_dir", o_pin_dir, 8'h00);
        chk("rst_out", o_pin_data, 8'h00);
        chk("rst_irq", W'(o_irq), 8'h00);
        req = 1'b0;
        pins = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, 3'd0, '0, rd);
        chk("ctrl_after_rst", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Memory-mapped controller for a WIDTH-bit bank of GPIO pins. It sits between the processor's peripheral bus and an array of gpio_one_pin instances.
- It holds the per-pin enable, direction and output registers.
- It synchronises the received pin values and reports rising edges as an interrupt.
- Bus accesses use a four-phase req/ack handshake sequenced by a small FSM.

Parameters:
- WIDTH, default 8: number of GPIO pins controlled; also the data-bus width.
- ADDR_W, default 3: register address width. 8 word slots.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  bus request; held high until o_ack is seen
- i_we  in  1  1 = write, 0 = read; stable while i_req is high
- i_addr  in  ADDR_W  register index; stable while i_req is high
- i_wdata  in  WIDTH  write data; stable while i_req is high
- o_rdata  out  WIDTH  read data; valid only while o_ack is high, 0 otherwise
- o_ack  out  1  access-complete strobe
- o_pin_enable  out  WIDTH  per-pin i_enable to the pin cells
- o_pin_dir  out  WIDTH  per-pin i_data_dir (1 = output)
- o_pin_data  out  WIDTH  per-pin i_data_transmit
- i_pin_data  in  WIDTH  per-pin o_data_received from the pin cells
- o_irq  out  1  level interrupt to the CPU

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs and registers are 0, o_ack = 0, FSM = IDLE.
- Register map:
  - 0 CTRL: RW, pin enable.
  - 1 DIR: RW.
  - 2 OUT: RW.
  - 3 IN: RO, synchronised input value.
  - 4 SET: WO. OUT |= wdata. Reads 0.
  - 5 CLR: WO. OUT &= ~wdata. Reads 0.
  - 6 IRQ_MASK: RW.
  - 7 IRQ_STAT: read; write-1-to-clear.
- Writes to RO addresses are ignored and still acked.
- Input path:
  - i_pin_data is gated by CTRL, so disabled or high-Z bits count as 0 and X/Z never propagates.
  - The gated value passes through a 2-flop synchroniser into IN.
  - Latency: a pin change reaches IN 2 edges after it appears on i_pin_data.
- Output mapping: o_pin_enable = CTRL, o_pin_dir = DIR, o_pin_data = OUT. These are direct register outputs with no extra stage.
- FSM states:
  - IDLE: on an edge where i_req = 1, perform the access (write committed at this edge, read data captured into o_rdata), set o_ack = 1, go to ACK.
  - ACK: o_ack = 1 for exactly one cycle; at the next edge clear o_ack and o_rdata, go to WAIT.
  - WAIT: stay until i_req = 0, then go to IDLE. This state prevents a held request from producing a second access.
- Access latency: o_ack rises 1 edge after i_req is sampled. Minimum access is 3 cycles including the release.
- Reset mid-access: the FSM returns to IDLE and o_ack drops immediately. The master must re-issue the access.
- Read data returns register contents as of the sampling edge, before any same-edge update.
- Interrupt: see Optional Feature.

Optional Feature:
- Macro: GPIO_PORT_CTRL_IRQ_EN
- Defined:
  - A third flop holds the previous IN value. A rising edge is IN & ~IN_prev.
  - IRQ_STAT[i] sets on a rising edge of bit i when IRQ_MASK[i] = 1.
  - A W1C write clears STAT bits, except that a same-cycle new edge on a bit wins and the bit stays 1.
  - o_irq is registered: o_irq = |(IRQ_STAT & IRQ_MASK), updated 1 edge after STAT changes.
  - Clearing the mask bit deasserts o_irq but leaves STAT intact.
- Undefined:
  - Addresses 6 and 7 read 0; writes are ignored and still acked.
  - o_irq is tied 0.
  - No edge-detect logic is instantiated.

Test Plan:
1. Reset/readback: assert i_rst_n = 0 mid-cycle -> all outputs 0 immediately. Release, read addresses 0–7 -> all 0, each access acked once.
2. Config write (WIDTH = 8): write CTRL = 0xFF, DIR = 0x0F, OUT = 0xA5 -> o_pin_enable = 0xFF, o_pin_dir = 0x0F, o_pin_data = 0xA5. o_ack high exactly 1 cycle per access, 1 edge after i_req sampled.
3. SET/CLR: OUT = 0xA5; write SET = 0x0A -> OUT 0xAF; write CLR = 0x21 -> OUT 0x8E. Reading addresses 4 and 5 returns 0.
4. Input sync and gating: CTRL = 0x0F, drive i_pin_data = 0xF3 -> IN reads 0x03 no earlier than 2 edges after the change. Driving X/Z on bits 7:4 still reads 0x03.
5. Handshake hold: keep i_req = 1 for 10 cycles on a SET write of 0x01 -> exactly one ack and one SET applied. Next access only after i_req drops.
6. IRQ (macro defined): MASK = 0x04; pin 2 goes 0→1 -> STAT = 0x04, o_irq = 1. W1C 0x04 issued in the same cycle as a new edge -> STAT stays 0x04. Later W1C 0x04 with no edge -> STAT = 0, o_irq = 0 one edge later. With the macro undefined, the same stimulus leaves o_irq = 0.
